// File: rtl/regbank_sb_pkg.sv
// Shared types for the scoreboarded register bank.
// FSM states and init-mode encodings.
package regbank_sb_pkg;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam int INIT_IDX  = 0;
  localparam int INIT_ZERO = 1;

endpackage

// File: rtl/regbank_sb_scoreboard.sv
// Busy-bit vector: claims set, writebacks clear.
// A same-cycle claim beats the clear on one address.
module regbank_sb_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_d;
  end

endmodule

// File: rtl/regbank_sb.sv
// Register bank with init sweep, write bypass
// and per-register busy scoreboard.
module regbank_sb
  import regbank_sb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_RD    = 2,
  parameter int ZERO_R0   = 1,
  parameter int INIT_MODE = INIT_IDX,
  localparam int ADDR_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     ready
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_d;
  logic                run;
  logic                wr_ok, clm_ok;
  logic [DATA_W-1:0]   init_val;
  logic [NUM_REGS-1:0] busy;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // Out-of-range and hard-zero r0 behave as absent.
  function automatic logic addr_ok(
    input logic [ADDR_W-1:0] a
  );
    return (int'(a) < NUM_REGS) &&
      !((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign run    = (state_q == S_RUN);
  assign wr_ok  = run && wr_en && addr_ok(wr_addr);
  assign clm_ok = run && claim_en &&
                  addr_ok(claim_addr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= ready_d;
    end
  end

  assign init_val = (INIT_MODE == INIT_ZERO) ?
    '0 : DATA_W'(cnt_q);

  always_ff @(posedge clk) begin
    if (!run)       regs[cnt_q]   <= init_val;
    else if (wr_ok) regs[wr_addr] <= wr_data;
  end

  regbank_sb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (clm_ok),
    .set_addr (claim_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .busy     (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              ok;

    assign a  = rd_addr[k*ADDR_W +: ADDR_W];
    assign ok = run && addr_ok(a);

    always_comb begin
      d = '0;
      if (ok)
        d = (wr_en && wr_addr == a) ?
          wr_data : regs[a];
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k] = ok && busy[a];
  end

endmodule

// File: tb/tb_regbank_sb.sv
// Directed bench: default bank plus a 24-deep,
// 3-port, zero-init bank sharing clock and reset.
module tb_regbank_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        ready;

  logic [14:0] rd_addr2;
  logic [95:0] rd_data2;
  logic [2:0]  rd_busy2;
  logic        wr_en2;
  logic [4:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic        claim_en2;
  logic [4:0]  claim_addr2;
  logic        ready2;

  regbank_sb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .ready      (ready)
  );

  regbank_sb #(
    .NUM_REGS  (24),
    .NUM_RD    (3),
    .INIT_MODE (1)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr2),
    .rd_data    (rd_data2),
    .rd_busy    (rd_busy2),
    .wr_en      (wr_en2),
    .wr_addr    (wr_addr2),
    .wr_data    (wr_data2),
    .claim_en   (claim_en2),
    .claim_addr (claim_addr2),
    .ready      (ready2)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t tv [15];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after rst rises.
  task automatic sweep(input string nm);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk($sformatf("%s rdy %0d", nm, i),
          ready, i >= 32);
      chk($sformatf("%s rdy2 %0d", nm, i),
          ready2, i >= 24);
      if (i == 16) begin
        chk({nm, " init rd"}, rd_data, 0);
        chk({nm, " init busy"}, rd_busy, 0);
      end
    end
  endtask

  initial begin
    tv[0]  = '{1, 7, 32'hDEADBEEF, 0, 0, 7, 8,
               32'hDEADBEEF, 8, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 7, 0,
               32'hDEADBEEF, 0, 0};
    tv[2]  = '{0, 0, 0, 1, 9, 9, 7,
               9, 32'hDEADBEEF, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 9, 10, 9, 10, 1};
    tv[4]  = '{1, 9, 32'h99, 1, 9, 9, 9,
               32'h99, 32'h99, 3};
    tv[5]  = '{0, 0, 0, 0, 0, 9, 9,
               32'h99, 32'h99, 3};
    tv[6]  = '{1, 9, 32'hAA, 0, 0, 9, 9,
               32'hAA, 32'hAA, 3};
    tv[7]  = '{0, 0, 0, 0, 0, 9, 9,
               32'hAA, 32'hAA, 0};
    tv[8]  = '{1, 0, 32'h1234, 1, 0, 0, 0,
               0, 0, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 9,
               0, 32'hAA, 0};
    tv[10] = '{0, 0, 0, 1, 9, 9, 9,
               32'hAA, 32'hAA, 0};
    tv[11] = '{0, 0, 0, 1, 9, 9, 9,
               32'hAA, 32'hAA, 3};
    tv[12] = '{0, 0, 0, 0, 0, 9, 31,
               32'hAA, 31, 1};
    tv[13] = '{1, 31, 32'h5555AAAA, 0, 0, 5, 31,
               5, 32'h5555AAAA, 0};
    tv[14] = '{0, 0, 0, 0, 0, 31, 7,
               32'h5555AAAA, 32'hDEADBEEF, 0};

    rst = 1'b0;
    rd_addr = {5'd5, 5'd3};
    wr_en = 0; wr_addr = 0; wr_data = 0;
    claim_en = 0; claim_addr = 0;
    rd_addr2 = 0;
    wr_en2 = 0; wr_addr2 = 0; wr_data2 = 0;
    claim_en2 = 0; claim_addr2 = 0;
    repeat (3) tick();
    chk("rst ready", ready, 0);
    chk("rst ready2", ready2, 0);
    chk("rst busy", rd_busy, 0);
    chk("rst rd", rd_data, 0);

    wr_en = 1; wr_addr = 3; wr_data = '1;
    claim_en = 1; claim_addr = 3;
    rst = 1'b1;
    sweep("boot");
    wr_en = 0; claim_en = 0;

    rd_addr = {5'd31, 5'd5};
    #1;
    chk("boot rd 5/31", rd_data, {32'd31, 32'd5});
    rd_addr = {5'd3, 5'd3};
    #1;
    chk("init wr ignored", rd_data, {32'd3, 32'd3});
    chk("init claim ignored", rd_busy, 0);
    tick();

    for (int i = 0; i < 15; i++) begin
      wr_en      = tv[i].we;
      wr_addr    = tv[i].wa;
      wr_data    = tv[i].wd;
      claim_en   = tv[i].ce;
      claim_addr = tv[i].ca;
      rd_addr    = {tv[i].r1, tv[i].r0};
      #1;
      chk($sformatf("vec%0d d0", i),
          rd_data[31:0], tv[i].e0);
      chk($sformatf("vec%0d d1", i),
          rd_data[63:32], tv[i].e1);
      chk($sformatf("vec%0d busy", i),
          rd_busy, tv[i].eb);
      tick();
    end
    wr_en = 0; claim_en = 0;

    rd_addr = {5'd0, 5'd9};
    #1;
    chk("pre-rst busy9", rd_busy, 2'b01);
    rst = 1'b0;
    #1;
    chk("run rst ready", ready, 0);
    chk("run rst busy", rd_busy, 0);
    chk("run rst ready2", ready2, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("part rdy %0d", i), ready, 0);
    end
    rst = 1'b0;
    #1;
    chk("mid rst ready", ready, 0);
    chk("mid rst busy", rd_busy, 0);
    tick();
    wr_en = 1; wr_addr = 5; wr_data = 32'hABCD;
    claim_en = 1; claim_addr = 5;
    rst = 1'b1;
    sweep("resweep");
    wr_en = 0; claim_en = 0;
    rd_addr = {5'd7, 5'd5};
    #1;
    chk("resweep rd", rd_data, {32'd7, 32'd5});
    chk("resweep busy", rd_busy, 0);
    rd_addr = {5'd0, 5'd9};
    #1;
    chk("resweep rd9", rd_data, {32'd0, 32'd9});
    chk("resweep busy9", rd_busy, 0);

    for (int a = 0; a < 24; a++) begin
      rd_addr2 = {5'(a), 5'(a), 5'(23 - a)};
      #1;
      chk($sformatf("z init %0d", a),
          {rd_busy2, rd_data2}, 0);
    end
    wr_en2 = 1; wr_addr2 = 5; wr_data2 = 32'h77;
    rd_addr2 = {5'd30, 5'd23, 5'd5};
    #1;
    chk("z bypass", rd_data2, {64'd0, 32'h77});
    tick();
    wr_addr2 = 30; wr_data2 = '1;
    claim_en2 = 1; claim_addr2 = 30;
    #1;
    chk("z oor bypass", rd_data2, {64'd0, 32'h77});
    tick();
    wr_en2 = 0; claim_addr2 = 23;
    tick();
    claim_en2 = 0;
    #1;
    chk("z oor rd", rd_data2, {64'd0, 32'h77});
    chk("z busy", rd_busy2, 3'b010);
    for (int a = 0; a < 24; a++) begin
      rd_addr2 = {5'(a), 5'(a), 5'(a)};
      #1;
      chk($sformatf("z after %0d", a),
          {rd_busy2, rd_data2},
          {(a == 23) ? 3'b111 : 3'b000,
           {3{(a == 5) ? 32'h77 : 32'h0}}});
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
